// File: rtl/ram_stream_pkg.sv
// Shared types and width helpers for the RAM read-stream engine.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a length equal to the full depth is representable.
  function automatic int len_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of the RAM read-stream engine.
interface ram_stream_reader_if
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512,
  parameter int AW    = addr_width(DEPTH),
  parameter int LW    = len_width(DEPTH)
);
  logic             start;
  logic [AW-1:0]    start_addr;
  logic [LW-1:0]    length;
  logic             busy;
  logic             done;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  start, start_addr, length, ram_rd_data, m_ready,
    output busy, done, ram_rd_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, start_addr, length, ram_rd_data, m_ready,
    input  busy, done, ram_rd_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_rd_skid_buf.sv
// 2-entry valid/ready buffer; latency: push visible on pop side next cycle.
// Backpressure: no push_rdy, the producer must use count to avoid overflow.
module ram_rd_skid_buf #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [DW-1:0] pop_dat,
  output logic [1:0]    count
);
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [1:0]    count_q;
  logic          pop;

  assign pop     = pop_rdy && (count_q != 2'd0);
  assign pop_vld = (count_q != 2'd0);
  assign pop_dat = head_q;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (push_vld && pop) begin
      if (count_q == 2'd1) begin
        head_q <= push_dat;
      end else begin
        head_q <= tail_q;
        tail_q <= push_dat;
      end
    end else if (push_vld) begin
      if (count_q == 2'd0) begin
        head_q <= push_dat;
      end else if (count_q == 2'd1) begin
        tail_q <= push_dat;
      end
      if (count_q != 2'd2) count_q <= count_q + 2'd1;
    end else if (pop) begin
      // Head keeps its old value when the buffer empties, so m_data stays quiet.
      if (count_q == 2'd2) head_q <= tail_q;
      count_q <= count_q - 2'd1;
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// Walks length RAM words from start_addr onto a valid/ready stream; first beat 3 cycles after start.
// Backpressure: reads stall once buffered + in-flight words would exceed 2; 1 word/cycle otherwise.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input logic                 clk,
  input logic                 rst_n,
  ram_stream_reader_if.master bus
);
  localparam int AW = addr_width(DEPTH);
  localparam int LW = len_width(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic          inflight_q;
  logic          inflight_last_q;
  logic          done_q;

  logic          issue;
  logic          last_issue;
  logic          pop;
  logic          accept;
  logic          zero_cmd;
  logic          final_pop;
  logic [2:0]    occ;
  logic          credit_ok;

  logic          out_vld;
  logic [WIDTH:0] out_dat;
  logic [1:0]    count;

  ram_rd_skid_buf #(.DW(WIDTH + 1)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (inflight_q),
    .push_dat ({inflight_last_q, bus.ram_rd_data}),
    .pop_vld  (out_vld),
    .pop_rdy  (bus.m_ready),
    .pop_dat  (out_dat),
    .count    (count)
  );

  assign pop        = out_vld && bus.m_ready;
  assign last_issue = (rem_q == LW'(1));
  assign accept     = (state == IDLE) && bus.start && (bus.length != '0);
  assign zero_cmd   = (state == IDLE) && bus.start && (bus.length == '0);
  assign final_pop  = (state == DRAIN) && pop && out_dat[WIDTH];

  // A pop this cycle frees a slot in time for the word issued now.
  assign occ       = {1'b0, count} + {2'b00, inflight_q};
  assign credit_ok = occ < (3'd2 + {2'b00, pop});

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        issue = credit_ok && (rem_q != '0);
        if (issue && last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (final_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state           <= state_nxt;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
      done_q          <= zero_cmd || final_pop;
      if (accept) begin
        addr_q <= bus.start_addr;
        rem_q  <= bus.length;
      end else if (issue) begin
        rem_q <= rem_q - LW'(1);
        // The final read address is left on the port rather than advancing past it.
        if (!last_issue) addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.ram_rd_addr = addr_q;
  assign bus.m_valid     = out_vld;
  assign bus.m_data      = out_dat[WIDTH-1:0];
  assign bus.m_last      = out_dat[WIDTH];
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM[i]=i, randomized back-pressure, queue-based stream model.
module tb_ram_stream_reader;
  import ram_stream_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 512;
  localparam int AW    = addr_width(DEPTH);
  localparam int LW    = len_width(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) bus.ram_rd_data <= mem[bus.ram_rd_addr];

  int total = 0;
  int passed = 0;

  logic [WIDTH-1:0] exp_dat[$];
  logic             exp_last[$];
  logic [WIDTH-1:0] got_dat[$];
  logic             got_last[$];
  int               got_cyc[$];
  int first_v, done_cyc, done_cnt, busy_cnt, busy_at_done, stable_viol, timed_out;

  // Reference: a command yields words (addr+k) mod DEPTH, last flag on the final one.
  function automatic void build_expected(input int addr, input int len);
    exp_dat.delete();
    exp_last.delete();
    for (int k = 0; k < len; k++) begin
      exp_dat.push_back(WIDTH'((addr + k) % DEPTH));
      exp_last.push_back(k == len - 1);
    end
  endfunction

  // Called at posedge+1; start is sampled by the next edge (E0), returns at E0+1.
  task automatic start_cmd(input int addr, input int len);
    bus.start      = 1'b1;
    bus.start_addr = AW'(addr);
    bus.length     = LW'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Cycle c counts clock periods after E0; stops at the done cycle or after budget.
  task automatic collect(input int mode, input int budget, input int mid_c,
                         input int mid_addr, input int mid_len);
    logic pv, pr, pl;
    logic [WIDTH-1:0] pd;
    got_dat.delete(); got_last.delete(); got_cyc.delete();
    first_v = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_at_done = 0;
    stable_viol = 0; timed_out = 1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int c = 1; c <= budget; c++) begin
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (c % 6 == 1) || (c % 6 == 4) || (c % 6 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == mid_c) begin
        bus.start = 1'b1; bus.start_addr = AW'(mid_addr); bus.length = LW'(mid_len);
      end else if (c == mid_c + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (pv && !pr && (!bus.m_valid || bus.m_data !== pd || bus.m_last !== pl)) stable_viol++;
      if (bus.m_valid && first_v < 0) first_v = c;
      if (bus.m_valid && bus.m_ready) begin
        got_dat.push_back(bus.m_data); got_last.push_back(bus.m_last); got_cyc.push_back(c);
      end
      if (bus.busy) busy_cnt++;
      pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data; pl = bus.m_last;
      if (bus.done) begin
        done_cnt++; done_cyc = c; busy_at_done = int'(bus.busy); timed_out = 0;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (timed_out == 0) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); else passed++;
    total++; if (bus.m_last !== 1'b0) $display("FAIL reset_m_last: got %b want 0", bus.m_last); else passed++;
    total++; if (bus.m_data !== '0) $display("FAIL reset_m_data: got %0h want 0", bus.m_data); else passed++;
    total++; if (bus.ram_rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d want 0", bus.ram_rd_addr); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start_cmd(10, 4);
    collect(0, 40, -10, 0, 0);
    build_expected(10, 4);
    total++; if (timed_out != 0) $display("FAIL basic_timeout: no done within budget"); else passed++;
    total++; if (got_dat.size() != exp_dat.size()) $display("FAIL basic_count: got %0d beats want %0d", got_dat.size(), exp_dat.size()); else passed++;
    foreach (exp_dat[i]) if (i < got_dat.size()) begin
      total++;
      if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i])
        $display("FAIL basic_beat%0d: got %0d/last %b want %0d/last %b", i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
      else passed++;
    end
    total++; if (first_v != 3) $display("FAIL basic_first_valid: got cycle %0d want 3", first_v); else passed++;
    total++; if (got_cyc.size() != 4 || got_cyc[3] != 6) $display("FAIL basic_consecutive: last beat cycle %0d want 6", (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -1); else passed++;
    total++; if (done_cyc != 7) $display("FAIL basic_done_cycle: got %0d want 7", done_cyc); else passed++;
    total++; if (busy_at_done != 0) $display("FAIL basic_busy_at_done: got %0d want 0", busy_at_done); else passed++;
  endtask

  task automatic test_wrap();
    start_cmd(510, 4);
    collect(0, 40, -10, 0, 0);
    build_expected(510, 4);
    total++; if (got_dat.size() != exp_dat.size()) $display("FAIL wrap_count: got %0d beats want %0d", got_dat.size(), exp_dat.size()); else passed++;
    foreach (exp_dat[i]) if (i < got_dat.size()) begin
      total++;
      if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i])
        $display("FAIL wrap_beat%0d: got %0d/last %b want %0d/last %b", i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int addr, len;
    for (int n = 0; n < 8; n++) begin
      addr = (n == 0) ? 40 : int'($urandom_range(0, DEPTH - 1));
      len  = (n == 0) ? 4 : int'($urandom_range(1, 14));
      start_cmd(addr, len);
      collect((n == 0) ? 1 : 2, len * 10 + 40, -10, 0, 0);
      build_expected(addr, len);
      total++; if (got_dat.size() != exp_dat.size()) $display("FAIL bp%0d_count: got %0d beats want %0d", n, got_dat.size(), exp_dat.size()); else passed++;
      foreach (exp_dat[i]) if (i < got_dat.size()) begin
        total++;
        if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i])
          $display("FAIL bp%0d_beat%0d: got %0d/last %b want %0d/last %b", n, i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
        else passed++;
      end
      total++; if (stable_viol != 0) $display("FAIL bp%0d_stable: %0d stall violations want 0", n, stable_viol); else passed++;
      total++; if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1) $display("FAIL bp%0d_done_cycle: got %0d want last beat + 1", n, done_cyc); else passed++;
    end
  endtask

  task automatic test_zero_len();
    bus.m_ready = 1'b1;
    start_cmd(77, 0);
    collect(0, 10, -10, 0, 0);
    total++; if (done_cyc != 1) $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); else passed++;
    total++; if (first_v != -1 || got_dat.size() != 0) $display("FAIL zero_no_beats: first valid %0d beats %0d want none", first_v, got_dat.size()); else passed++;
    total++; if (busy_cnt != 0) $display("FAIL zero_busy: busy for %0d cycles want 0", busy_cnt); else passed++;
    repeat (2) @(negedge clk);
    total++; if (bus.m_valid !== 1'b0 || bus.done !== 1'b0) $display("FAIL zero_quiet: m_valid %b done %b want 0 0", bus.m_valid, bus.done); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_len();
    start_cmd(300, DEPTH);
    collect(0, DEPTH + 60, 100, 7, 3);
    build_expected(300, DEPTH);
    total++; if (got_dat.size() != exp_dat.size()) $display("FAIL full_count: got %0d beats want %0d", got_dat.size(), exp_dat.size()); else passed++;
    foreach (exp_dat[i]) if (i < got_dat.size()) begin
      total++;
      if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i])
        $display("FAIL full_beat%0d: got %0d/last %b want %0d/last %b", i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
      else passed++;
    end
    total++; if (done_cyc != DEPTH + 3) $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, DEPTH + 3); else passed++;
    repeat (6) @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) $display("FAIL full_mid_start_ignored: busy %b m_valid %b want 0 0", bus.busy, bus.m_valid); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    start_cmd(100, 3);
    collect(0, 40, 6, 200, 2);
    build_expected(100, 3);
    total++; if (done_cyc != 6) $display("FAIL b2b_first_done: got %0d want 6", done_cyc); else passed++;
    total++; if (got_dat.size() != 3 || got_dat[2] !== exp_dat[2] || got_last[2] !== 1'b1) $display("FAIL b2b_first_stream: %0d beats want 3 ending in %0d", got_dat.size(), exp_dat[2]); else passed++;
    collect(0, 40, -10, 0, 0);
    build_expected(200, 2);
    total++; if (first_v != 3) $display("FAIL b2b_second_first_valid: got %0d want 3", first_v); else passed++;
    total++; if (got_dat.size() != 2) $display("FAIL b2b_second_count: got %0d want 2", got_dat.size()); else passed++;
    foreach (exp_dat[i]) if (i < got_dat.size()) begin
      total++;
      if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i])
        $display("FAIL b2b_beat%0d: got %0d/last %b want %0d/last %b", i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    bus.m_ready = 1'b0;
    start_cmd(20, 8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++; if (seen != 1) $display("FAIL rstmid_valid_rises: got %0d want 1", seen); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rstmid_cleared: m_valid %b busy %b want 0 0", bus.m_valid, bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL rstmid_no_done: got %b want 0", bus.done); else passed++;
    repeat (3) @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.m_valid !== 1'b0) $display("FAIL rstmid_quiet: done %b m_valid %b want 0 0", bus.done, bus.m_valid); else passed++;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    test_basic();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_full_len();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side streaming engine for the team's simple dual-port block RAM, which has a 1-cycle registered read and no read enable. On a start command it walks `length` consecutive addresses from `start_addr`, absorbs the RAM's fixed read latency, and presents the words on a valid/ready stream with full back-pressure support and one word per cycle throughput. It sits between the RAM read port and any downstream consumer, such as a packetiser or DMA.

## Interface
- WIDTH, 8, data word width; must match the RAM.
- DEPTH, 512, RAM depth in words; need not be a power of two.
- AW, $clog2(DEPTH), address width (derived).
- LW, $clog2(DEPTH)+1, length width (derived); allows length = DEPTH.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  AW  first RAM address; sampled with start.
- length  in  LW  word count; sampled with start; legal range 0..DEPTH.
- busy  out  1  high while a command is in progress (state != IDLE).
- done  out  1  one-cycle pulse when a command completes.
- ram_rd_addr  out  AW  drives the RAM read address.
- ram_rd_data  in  WIDTH  RAM read data; corresponds to the address presented one cycle earlier.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  WIDTH  stream word.
- m_last  out  1  marks the final word of a command.

## Operation
- States:
  - IDLE: `start` with `length` != 0 latches the address and count, then goes to RUN. `start` with `length` == 0 pulses `done` in the next cycle, stays in IDLE, and emits no beats.
  - RUN: issues one read per cycle while credit allows. After the final issue, goes to DRAIN.
  - DRAIN: waits until the final beat is handshaken, then goes to IDLE with `done` pulsed.
- `start` is ignored while `busy` is high.
- Address increments by 1 per issue. It wraps from DEPTH-1 to 0 by explicit compare, not by modular truncation.
- `ram_rd_addr` holds its last value when no read is issued. Its reset value is 0.
- Issue tracking: a 1-bit `inflight` flag is set in the cycle a read is issued. In the following cycle, `ram_rd_data` is written into the output buffer.
- Output buffer: a 2-entry skid FIFO.
  - Issue is permitted when (entries + inflight − pop_this_cycle) < 2, so the buffer can never overflow.
  - Data returns from the RAM every cycle whether or not a read was issued. Only cycles flagged by `inflight` are captured.
- Stream rules:
  - Once `m_valid` rises, `m_data` and `m_last` hold stable until `m_valid && m_ready`.
  - `m_valid` never drops without a handshake.
  - `m_last` is high only on beat `length`−1.
- Remaining-count width is LW, so `length` = DEPTH reads every word once, starting at `start_addr` and wrapping.
- Reset asserted mid-command: next state is IDLE, the buffer is emptied, `inflight` is cleared, and no `done` is produced.
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `ram_rd_addr`=0.

## Timing
- Pipeline for a `start` sampled at edge E0:
  - Cycle after E0: state is RUN and `ram_rd_addr` = `start_addr`.
  - 2 cycles after E0: `ram_rd_data` is valid.
  - 3 cycles after E0: first `m_valid`.
- Throughput is 1 word per cycle while `m_ready` stays high. This is sustained with 1 entry buffered and 1 read in flight.
- If `m_ready` is low, at most 2 words are held: 1 buffered plus 1 in flight, or 2 buffered. Issue stalls.
- When `m_ready` returns, the next beat follows in the same cycle if buffered. No bubble is allowed when the buffer is non-empty.
- `done` pulses in the cycle after the `m_last` handshake. `busy` is low in that same cycle.
- A new `start` is accepted in the `done` cycle.

## Structure
- Shared package `ram_stream_pkg` holds the state enum (IDLE, RUN, DRAIN) and the function for AW/LW derivation.
- One sub-module: `ram_rd_skid_buf`, the 2-entry valid/ready buffer with a push port, a pop port and a `count` output.
- The RAM is instantiated outside this block. The bench instantiates the team's dual-port RAM alongside it.

## Test plan
- Preload RAM[i]=i. Start with start_addr=10, length=4, m_ready=1 → beats 10,11,12,13 on consecutive cycles; first m_valid 3 cycles after start; m_last on 13; done 1 cycle later.
- Start with start_addr=510, length=4, DEPTH=512 → beats 510,511,0,1; m_last on 1.
- Length=4 with m_ready toggled 1,0,0,1,0,1… → all 4 words delivered in order with no duplicates or losses; m_data stable while stalled; never more than 2 issues ahead of pops.
- Start with length=0 → done pulses in the next cycle; m_valid never rises; busy stays 0.
- Start with length=512 and m_ready=1 → 512 beats, wrapping once; a start asserted mid-run is ignored.
- rst_n low for 1 cycle mid-command with m_valid high → next cycle m_valid=0, busy=0, no done; a fresh start then behaves as in the first scenario.
